// File: rtl/exe_stage_bju_pkg.sv
// Shared constants for the branch/jump unit: compare-flag bus layout, FSM states, link offset.
package exe_stage_bju_pkg;

    localparam int BJ_BUS  = 8;
    localparam int BJ_BEQ  = 0;
    localparam int BJ_BNE  = 1;
    localparam int BJ_BLT  = 2;
    localparam int BJ_BGE  = 3;
    localparam int BJ_BLTU = 4;
    localparam int BJ_BGEU = 5;
    localparam int BJ_JALR = 6;
    localparam int BJ_JAL  = 7;

    localparam int BJU_LINK_OFFSET = 4;

    typedef enum logic {
        BJU_IDLE    = 1'b0,
        BJU_PENDING = 1'b1
    } bju_state_e;

endpackage

// File: rtl/exe_stage_bju_target.sv
// Combinational taken decision, target PC and link-instruction detect for the branch/jump unit.
module exe_stage_bju_target
    import exe_stage_bju_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   op1,
    input  logic [BJ_BUS-1:0] bj_info,
    input  logic [BJ_BUS-1:0] bj_data,
    output logic              taken,
    output logic              is_link,
    output logic [XLEN-1:0]   target
);

    logic [BJ_BUS-1:0] hit;
    logic [XLEN-1:0]   jalr_sum;
    logic [XLEN-1:0]   rel_sum;

    // A type only counts when the ALU flag for that same type agrees.
    for (genvar gi = 0; gi < BJ_BUS; gi++) begin : g_hit
        assign hit[gi] = bj_info[gi] & bj_data[gi];
    end

    assign taken    = |hit;
    assign is_link  = bj_info[BJ_JAL] | bj_info[BJ_JALR];
    assign jalr_sum = op1 + imm;
    assign rel_sum  = pc + imm;
    assign target   = bj_info[BJ_JALR] ? {jalr_sum[XLEN-1:1], 1'b0} : rel_sum;

endmodule

// File: rtl/exe_stage_bju.sv
// Branch/jump resolution unit: registered redirect handshake to fetch, flush, and link writeback.
// Optional performance counters are compiled in when BJU_PERF_CNT_EN is defined.
module exe_stage_bju
    import exe_stage_bju_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int LINK_OFFSET = BJU_LINK_OFFSET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   op1,
    input  logic [BJ_BUS-1:0] bj_info,
    input  logic [BJ_BUS-1:0] bj_data,
    output logic              redirect_valid,
    input  logic              redirect_ready,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush,
    output logic              link_valid,
    output logic [XLEN-1:0]   link_data
`ifdef BJU_PERF_CNT_EN
    ,
    output logic [63:0]       perf_br_cnt,
    output logic [63:0]       perf_taken_cnt
`endif
);

    bju_state_e      state_reg, state_next;
    logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;
    logic            link_valid_reg;
    logic [XLEN-1:0] link_data_reg;

    logic            taken;
    logic            is_link;
    logic [XLEN-1:0] target;
    logic            accept;

    exe_stage_bju_target #(.XLEN(XLEN)) u_target (
        .pc      (pc),
        .imm     (imm),
        .op1     (op1),
        .bj_info (bj_info),
        .bj_data (bj_data),
        .taken   (taken),
        .is_link (is_link),
        .target  (target)
    );

    assign in_ready = (state_reg == BJU_IDLE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_next       = state_reg;
        redirect_pc_next = redirect_pc_reg;
        case (state_reg)
            BJU_IDLE: begin
                if (accept && taken) begin
                    state_next       = BJU_PENDING;
                    redirect_pc_next = target;
                end
            end
            BJU_PENDING: begin
                // Target stays frozen until fetch takes it; younger EXE traffic is ignored.
                if (redirect_ready) begin
                    state_next       = BJU_IDLE;
                    redirect_pc_next = '0;
                end
            end
            default: begin
                state_next       = BJU_IDLE;
                redirect_pc_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= BJU_IDLE;
            redirect_pc_reg <= '0;
            link_valid_reg  <= 1'b0;
            link_data_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            redirect_pc_reg <= redirect_pc_next;
            link_valid_reg  <= accept & is_link;
            link_data_reg   <= (accept & is_link) ? (pc + XLEN'(LINK_OFFSET)) : '0;
        end
    end

    assign redirect_valid = (state_reg == BJU_PENDING);
    assign flush          = (state_reg == BJU_PENDING);
    assign redirect_pc    = redirect_pc_reg;
    assign link_valid     = link_valid_reg;
    assign link_data      = link_data_reg;

`ifdef BJU_PERF_CNT_EN
    logic [63:0] perf_br_cnt_reg;
    logic [63:0] perf_taken_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_cnt_reg    <= '0;
            perf_taken_cnt_reg <= '0;
        end else begin
            if (accept && (bj_info != '0)) perf_br_cnt_reg <= perf_br_cnt_reg + 64'd1;
            if (accept && taken)           perf_taken_cnt_reg <= perf_taken_cnt_reg + 64'd1;
        end
    end

    assign perf_br_cnt    = perf_br_cnt_reg;
    assign perf_taken_cnt = perf_taken_cnt_reg;
`endif

endmodule

// File: doc/exe_stage_bju.md
Name: exe_stage_bju

Overview:
- Branch/jump resolution unit; the consumer end of the ALU's `bj_data` compare-flag bus.
- Sits in EXE beside the ALU. Combines the decoded branch type with the ALU flags and the operands to decide whether a branch or jump is taken.
- When taken, computes the target PC and issues a registered redirect to the fetch stage with a valid/ready handshake, flushing younger instructions until fetch accepts.
- Also produces the registered link value (pc+4) for JAL/JALR writeback.

Parameters:
- XLEN, 64, datapath and PC width.
- LINK_OFFSET, 4, byte offset added to pc for the link value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EXE instruction valid
- in_ready  out  1  unit can accept an instruction
- pc  in  XLEN  PC of the EXE instruction
- imm  in  XLEN  sign-extended B/J/I immediate
- op1  in  XLEN  rs1 value (JALR base)
- bj_info  in  8  one-hot branch type, bit order `BJ_BEQ..`BJ_JAL
- bj_data  in  8  ALU compare flags, same bit order
- redirect_valid  out  1  redirect request to fetch
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  XLEN  target PC
- flush  out  1  kill all instructions younger than the branch
- link_valid  out  1  link value valid for writeback
- link_data  out  XLEN  pc+LINK_OFFSET

Behaviour:
- Reset, synchronous, active-high (rst=1 at posedge):
  - state=IDLE; redirect_valid=0, redirect_pc=0, flush=0, link_valid=0, link_data=0.
  - Reset mid-PENDING abandons the request.
- States: IDLE, PENDING.
- in_ready = (state==IDLE). Accept = in_valid & in_ready.
- taken = |(bj_info & bj_data).
  - bj_info==0: non-branch, never taken, no effect.
  - Multi-hot bj_info is illegal; the RTL still uses the OR.
- Target:
  - JALR: (op1+imm) & ~1.
  - Otherwise: pc+imm.
  - All adds are modulo 2^XLEN; wrap-around is silent.
- Link: if accept and bj_info has JAL or JALR, then next cycle link_valid=1 and link_data=pc+LINK_OFFSET (wraps); otherwise link_valid=0. link_valid is a 1-cycle pulse, independent of state.
- IDLE, accept & taken: next cycle state=PENDING, redirect_valid=1, redirect_pc=target. No branch prediction: a taken branch whose target equals pc+4 still redirects.
- IDLE, otherwise: stay IDLE; outputs 0.
- PENDING:
  - redirect_valid=1 and flush=1.
  - redirect_pc is held stable.
  - in_valid is ignored, because those instructions are younger and flushed.
  - On redirect_valid & redirect_ready: next cycle IDLE, redirect_valid=0, flush=0.
  - redirect_ready low: stay PENDING indefinitely.
- flush = (state==PENDING), driven from the register.
- Latency: redirect asserted 1 cycle after accept. Minimum redirect occupancy is 1 cycle, when ready is already high. Back-to-back taken branches are impossible, since in_ready is low during PENDING.
- redirect_ready while not PENDING is ignored.

Optional Feature:
- Macro BJU_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_br_cnt (64) and perf_taken_cnt (64), both reset to 0.
  - perf_br_cnt increments on each accept with bj_info!=0.
  - perf_taken_cnt increments on each accept with taken=1.
  - Both wrap at 2^64.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- `BJ_BUS width and `BJ_BEQ..`BJ_JAL bit indices stay in defines.v, shared with the ALU and decoder.
- Add to defines.v: `BJU_IDLE and `BJU_PENDING state encodings, and `LINK_OFFSET.
- One natural sub-module: exe_stage_bju_target, the combinational target and taken computation. The FSM and registers stay in the top.

Test Plan:
- Reset: with rst=1 for 2 cycles and redirect_ready=0 -> all outputs 0; in_ready=1 after release.
- BEQ taken, ready high: pc=0x8000_0000, imm=0x10, bj_info=bj_data=BEQ bit, redirect_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x8000_0010, flush=1. One cycle later all deasserted; link_valid stays 0.
- BNE not taken: bj_info=BNE, bj_data BNE bit=0 -> no redirect, no flush, in_ready stays 1.
- JALR with backpressure:
  - Stimulus: op1=0x8000_1003, imm=0x4, pc=0x8000_0100, redirect_ready=0 for 3 cycles.
  - Link: link_valid pulse with link_data=0x8000_0104.
  - Redirect: redirect_pc=0x8000_1006 held and flush=1 for 4 cycles; in_valid=1 during PENDING is ignored.
  - Release: IDLE after the handshake.
- Wrap: JAL pc=0xFFFF_FFFF_FFFF_FFFC, imm=0x8 -> redirect_pc=0x4, link_data=0x0.
- Reset mid-PENDING: rst=1 while redirect_ready=0 -> next cycle redirect_valid=0, flush=0, state IDLE. With BJU_PERF_CNT_EN, the counters read 0 after reset and 2/1 after one taken plus one not-taken branch.
